// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI subordinate endpoint.
// Frame width, bit-counter width, mode struct and FSM state encoding.
package spi_pkg;

  localparam int SPI_FRAME_BITS = 8;
  localparam int SPI_CNT_W      = $clog2(SPI_FRAME_BITS);

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } spi_s_state_e;

  function automatic logic is_last_bit(input logic [SPI_CNT_W-1:0] cnt);
    return cnt == SPI_CNT_W'(SPI_FRAME_BITS - 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, plus one extra flop
// giving rise/fall strobes on the synchronised level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_q;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the value from before the clock edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_q    <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_q    <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = o_sync & ~r_q;
  assign o_fall = ~o_sync & r_q;

endmodule

// File: rtl/spi_s_core.sv
// SPI subordinate endpoint: oversampled pins, LSB-first 8-bit frames,
// valid/ready rx/tx byte streams with sticky overrun/underrun flags.
module spi_s_core
  import spi_pkg::*;
#(
  parameter int                        SYNC_STAGES = 2,
  parameter logic [SPI_FRAME_BITS-1:0] IDLE_BYTE   = 8'hFF
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_cpol,
  input  logic                      i_cpha,
  input  logic                      i_spi_cs_n,
  input  logic                      i_spi_sck,
  input  logic                      i_spi_mosi,
  output logic                      o_spi_miso,
  output logic                      o_spi_miso_oe,
  output logic [SPI_FRAME_BITS-1:0] o_rx_data,
  output logic                      o_rx_valid,
  input  logic                      i_rx_ready,
  input  logic [SPI_FRAME_BITS-1:0] i_tx_data,
  input  logic                      i_tx_valid,
  output logic                      o_tx_ready,
  output logic                      o_overrun,
  output logic                      o_underrun,
  input  logic                      i_clr_flags
);

  spi_s_state_e              r_state, w_state_nxt;
  spi_mode_t                 r_mode;
  logic [SPI_CNT_W-1:0]      r_bit_cnt, r_sh_cnt;
  logic [SPI_FRAME_BITS-1:0] r_rx_sh, r_rx_data, r_tx_sh, r_hold;
  logic                      r_rx_done, r_rx_valid, r_hold_full, r_fresh;
  logic                      r_miso, r_overrun, r_underrun;

  logic w_cs_s, w_cs_rise, w_cs_fall;
  logic w_sck_s, w_sck_rise, w_sck_fall;
  logic w_mosi_s, w_mosi_rise, w_mosi_fall;
  logic w_lead, w_trail, w_sample_edge, w_shift_edge;
  logic w_active, w_do_sample, w_do_shift, w_hold_shift, w_reload;
  logic w_tx_take, w_rx_load, w_rx_drop;
  logic [SPI_FRAME_BITS-1:0] w_tx_byte, w_rx_next;
  logic w_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_spi_cs_n),
    .o_sync  (w_cs_s),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_spi_sck),
    .o_sync  (w_sck_s),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_spi_mosi),
    .o_sync  (w_mosi_s),
    .o_rise  (w_mosi_rise),
    .o_fall  (w_mosi_fall)
  );

  assign w_unused = ^{w_cs_rise, w_sck_s, w_mosi_rise, w_mosi_fall};

  // Leading edge leaves the idle level; the mode is frozen once selected.
  assign w_lead        = r_mode.cpol ? w_sck_fall : w_sck_rise;
  assign w_trail       = r_mode.cpol ? w_sck_rise : w_sck_fall;
  assign w_sample_edge = r_mode.cpha ? w_trail : w_lead;
  assign w_shift_edge  = r_mode.cpha ? w_lead  : w_trail;

  assign w_active     = (r_state == ACTIVE) && !w_cs_s;
  assign w_do_sample  = w_active && w_sample_edge;
  assign w_do_shift   = w_active && w_shift_edge;
  assign w_hold_shift = r_mode.cpha && r_fresh;
  assign w_reload     = (r_state == LOAD) ||
                        (w_do_shift && (r_mode.cpha ? (r_sh_cnt == '0 && !r_fresh)
                                                    : is_last_bit(r_sh_cnt)));
  assign w_tx_byte    = r_hold_full ? r_hold : IDLE_BYTE;
  assign w_tx_take    = i_tx_valid && !r_hold_full;
  assign w_rx_next    = {w_mosi_s, r_rx_sh[SPI_FRAME_BITS-1:1]};
  assign w_rx_load    = r_rx_done && (!r_rx_valid || i_rx_ready);
  assign w_rx_drop    = r_rx_done && r_rx_valid && !i_rx_ready;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: next state takes a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = ACTIVE;
      ACTIVE:  if (w_cs_s) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_mode <= '0;
    end else if (w_cs_s) begin
      r_mode.cpol <= i_cpol;
      r_mode.cpha <= i_cpha;
    end
  end

  // NOTE: the byte registers are reset as well, so rx_data reads 0 after reset.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_sh     <= '0;
      r_miso      <= 1'b0;
      r_sh_cnt    <= '0;
      r_fresh     <= 1'b0;
    end else begin
      if (w_tx_take) begin
        r_hold      <= i_tx_data;
        r_hold_full <= 1'b1;
      end else if (w_reload) begin
        r_hold_full <= 1'b0;
      end
      if (w_reload) begin
        r_tx_sh <= w_tx_byte;
        r_miso  <= w_tx_byte[0];
      end else if (w_do_shift && !w_hold_shift) begin
        r_tx_sh <= r_tx_sh >> 1;
        r_miso  <= r_tx_sh[1];
      end
      // With cpha=1 the first leading edge of a frame only presents bit 0.
      if (r_state == LOAD) begin
        r_sh_cnt <= '0;
        r_fresh  <= 1'b1;
      end else if (w_do_shift) begin
        r_sh_cnt <= r_sh_cnt + 1'b1;
        r_fresh  <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_bit_cnt  <= '0;
      r_rx_sh    <= '0;
      r_rx_done  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (!w_active)        r_bit_cnt <= '0;
      else if (w_do_sample) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_do_sample) r_rx_sh <= w_rx_next;
      r_rx_done <= w_do_sample && is_last_bit(r_bit_cnt);
      if (w_rx_load) begin
        r_rx_data  <= r_rx_sh;
        r_rx_valid <= 1'b1;
      end else if (i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      r_overrun  <= w_rx_drop || (r_overrun && !i_clr_flags);
      r_underrun <= (w_reload && !r_hold_full) || (r_underrun && !i_clr_flags);
    end
  end

  assign o_spi_miso    = r_miso;
  assign o_spi_miso_oe = (r_state != IDLE);
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_ready    = !r_hold_full;
  assign o_overrun     = r_overrun;
  assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_spi_s_core.sv
// Bench for spi_s_core: a behavioural SPI manager drives the pins, and a
// scoreboard queue holds expected rx bytes that a monitor pops on each handshake.
module tb_spi_s_core;
  import spi_pkg::*;

  logic       clk = 1'b0, rst = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0, cs_n = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic       miso, miso_oe, rx_valid, tx_ready, overrun, underrun;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;
  logic       rx_ready = 1'b1, tx_valid = 1'b0, clr_flags = 1'b0;
  logic [7:0] mi;
  logic [7:0] exp_q[$];
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  spi_s_core dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_cpol        (cpol),
    .i_cpha        (cpha),
    .i_spi_cs_n    (cs_n),
    .i_spi_sck     (sck),
    .i_spi_mosi    (mosi),
    .o_spi_miso    (miso),
    .o_spi_miso_oe (miso_oe),
    .o_rx_data     (rx_data),
    .o_rx_valid    (rx_valid),
    .i_rx_ready    (rx_ready),
    .i_tx_data     (tx_data),
    .i_tx_valid    (tx_valid),
    .o_tx_ready    (tx_ready),
    .o_overrun     (overrun),
    .o_underrun    (underrun),
    .i_clr_flags   (clr_flags)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %0h expected no byte", rx_data);
      end else begin
        check("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sck  = p;
    tick(6);
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    tick(1);
  endtask

  task automatic send_tx(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 50) begin
      tick(1);
      n++;
    end
    check("tx_ready_wait", 8'(tx_ready), 8'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  // Manager: half SCK period of 4 clocks, LSB first, reads MISO on its sample edge.
  task automatic xfer(input logic [7:0] mo, input int edges, output logic [7:0] mi_o);
    mi_o = 8'h00;
    for (int e = 0; e < edges; e++) begin
      if (!cpha && e == 0) mosi = mo[0];
      tick(4);
      sck = ~sck;
      if ((e % 2 == 0) == !cpha) mi_o[e/2] = miso;
      else if (cpha)             mosi = mo[e/2];
      else if (e / 2 < 7)        mosi = mo[e/2 + 1];
    end
    tick(4);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    tick(8);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
    check(name, 8'(exp_q.size()), 8'd0);
  endtask

  task automatic frame(input logic [7:0] mo, input logic [7:0] exp_mi, input string name);
    exp_q.push_back(mo);
    cs_low();
    xfer(mo, 16, mi);
    cs_high();
    check(name, mi, exp_mi);
    drain({name, "_drain"});
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(4);
    check("rst_miso", 8'(miso), 8'd0);
    check("rst_oe", 8'(miso_oe), 8'd0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", 8'(rx_valid), 8'd0);
    check("rst_tx_ready", 8'(tx_ready), 8'd1);
    check("rst_overrun", 8'(overrun), 8'd0);
    check("rst_underrun", 8'(underrun), 8'd0);
    check("rst_state", 8'(dut.r_state), 8'(IDLE));
    check("rst_bit_cnt", 8'(dut.r_bit_cnt), 8'd0);

    set_mode(1'b0, 1'b0);
    send_tx(8'hA5);
    frame(8'h3C, 8'hA5, "mode0_miso");

    for (int m = 1; m < 4; m++) begin
      logic [1:0] md;
      md = 2'(m);
      set_mode(md[1], md[0]);
      send_tx(8'h81);
      frame(8'h81, 8'h81, $sformatf("mode%0d_miso", m));
    end

    // Back-to-back frames with the consumer stalled.
    set_mode(1'b0, 1'b0);
    pulse_clr();
    rx_ready = 1'b0;
    send_tx(8'h12);
    exp_q.push_back(8'h11);
    cs_low();
    send_tx(8'h34);
    xfer(8'h11, 16, mi);
    check("b2b_miso0", mi, 8'h12);
    xfer(8'h22, 16, mi);
    check("b2b_miso1", mi, 8'h34);
    cs_high();
    check("b2b_overrun", 8'(overrun), 8'd1);
    check("b2b_rx_data", rx_data, 8'h11);
    check("b2b_rx_valid", 8'(rx_valid), 8'd1);
    pulse_clr();
    check("b2b_overrun_clr", 8'(overrun), 8'd0);
    check("b2b_rx_data_kept", rx_data, 8'h11);
    rx_ready = 1'b1;
    drain("b2b_drain");

    // Underrun: nothing queued for transmit.
    pulse_clr();
    check("udr_clr", 8'(underrun), 8'd0);
    exp_q.push_back(8'h6E);
    cs_low();
    check("udr_set", 8'(underrun), 8'd1);
    xfer(8'h6E, 16, mi);
    check("udr_miso", mi, 8'hFF);
    check("udr_tx_ready", 8'(tx_ready), 8'd1);
    cs_high();
    drain("udr_drain");

    // Abort after four SCK edges.
    cs_low();
    xfer(8'h5A, 4, mi);
    cs_n = 1'b1;
    tick(6);
    check("abort_oe", 8'(miso_oe), 8'd0);
    check("abort_state", 8'(dut.r_state), 8'(IDLE));
    check("abort_bit_cnt", 8'(dut.r_bit_cnt), 8'd0);
    check("abort_rx_valid", 8'(rx_valid), 8'd0);
    tick(4);
    frame(8'h5A, 8'hFF, "abort_next_miso");

    // Reset in the middle of a frame.
    cs_low();
    xfer(8'hC3, 6, mi);
    check("pre_rst_oe", 8'(miso_oe), 8'd1);
    rst = 1'b1;
    #1;
    check("midrst_miso", 8'(miso), 8'd0);
    check("midrst_oe", 8'(miso_oe), 8'd0);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_valid", 8'(rx_valid), 8'd0);
    check("midrst_tx_ready", 8'(tx_ready), 8'd1);
    check("midrst_overrun", 8'(overrun), 8'd0);
    check("midrst_underrun", 8'(underrun), 8'd0);
    cs_n = 1'b1;
    sck  = cpol;
    tick(4);
    rst = 1'b0;
    tick(6);
    frame(8'hC3, 8'hFF, "post_rst_miso");

    drain("final_drain");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
